// File: rtl/decoder_5to32.sv
// Binary-to-one-hot decoder with a zero-latency combinational output and a
// registered copy for pipelined consumers (register-file write enables).
module decoder_5to32 #(
  parameter int AW   = 5,
  parameter int NOUT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [AW-1:0]   A,
  output logic [NOUT-1:0] F,
  output logic [NOUT-1:0] F_q,
  output logic            valid_q
);

  if (NOUT != (1 << AW)) begin : g_bad_nout
    $error("decoder_5to32: NOUT must equal 2**AW");
  end

  localparam logic [NOUT-1:0] ONE = {{(NOUT-1){1'b0}}, 1'b1};

  // An unknown en falls to the default arm and an unknown A poisons the shift,
  // so simulation sees all-X instead of a plausible but wrong one-hot value.
  always_comb begin
    F = '0;
    case (en)
      1'b1:    F = ONE << A;
      1'b0:    F = '0;
      default: F = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      F_q     <= F;
      valid_q <= en;
    end
  end

  a_onehot_f : assert property (@(posedge clk) $onehot0(F));
  a_onehot_fq : assert property (@(posedge clk) $onehot0(F_q));

endmodule

// File: tb/tb_decoder_5to32.sv
// Directed and randomised checks of decoder_5to32 against hand-computed
// expectations and a small one-cycle-delay reference model.
module tb_decoder_5to32;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  A;
  logic [31:0] F;
  logic [31:0] F_q;
  logic        valid_q;

  int compared   = 0;
  int mismatched = 0;

  logic       rf_mode;
  logic [7:0] din;
  logic [7:0] regs [32];

  always #5 clk = ~clk;

  decoder_5to32 #(.AW(5), .NOUT(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .A       (A),
    .F       (F),
    .F_q     (F_q),
    .valid_q (valid_q)
  );

  // Tiny register file using the decoder as write enables; register 0 stays zero.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
    end else if (rf_mode && en) begin
      for (int i = 1; i < 32; i++) if (F[i]) regs[i] <= din;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [4:0] a);
    @(negedge clk);
    en = e;
    A  = a;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_f;
    logic [31:0] exp_q;
    logic        exp_v;
    logic        r_en;
    logic [4:0]  r_a;

    rst = 1'b1; en = 1'b0; A = 5'd0; rf_mode = 1'b0; din = 8'h00;

    // Reset state before any clock edge
    #2;
    checkOutput("reset_fq", F_q, 32'h0000_0000);
    checkOutput("reset_valid", {31'b0, valid_q}, 32'h0);
    en = 1'b1; A = 5'd3; #1;
    checkOutput("f_live_in_reset", F, 32'h0000_0008);
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_hold_fq", F_q, 32'h0000_0000);
    checkOutput("reset_hold_valid", {31'b0, valid_q}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Exhaustive enabled sweep with one-cycle registered check
    for (int i = 0; i < 32; i++) begin
      exp_f = 32'h1 << i;
      applyStimulus(1'b1, 5'(i));
      checkOutput("sweep_f", F, exp_f);
      checkOutput("sweep_popcount", 32'($countones(F)), 32'd1);
      @(posedge clk); #1;
      checkOutput("sweep_fq", F_q, exp_f);
      checkOutput("sweep_valid", {31'b0, valid_q}, 32'h1);
    end

    // Boundary addresses
    applyStimulus(1'b1, 5'd0);  checkOutput("bound_a0", F, 32'h0000_0001);
    applyStimulus(1'b1, 5'd31); checkOutput("bound_a31", F, 32'h8000_0000);
    applyStimulus(1'b1, 5'd16); checkOutput("bound_a16", F, 32'h0001_0000);

    // Enable gating
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'(i));
      checkOutput("gated_f", F, 32'h0000_0000);
    end
    @(posedge clk); #1;
    checkOutput("gated_fq", F_q, 32'h0000_0000);
    checkOutput("gated_valid", {31'b0, valid_q}, 32'h0);

    // Asynchronous reset pulse between edges
    applyStimulus(1'b1, 5'd10);
    @(posedge clk); #1;
    checkOutput("pre_rst_fq", F_q, 32'h0000_0400);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_fq", F_q, 32'h0000_0000);
    checkOutput("async_rst_valid", {31'b0, valid_q}, 32'h0);
    checkOutput("async_rst_f", F, 32'h0000_0400);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_fq", F_q, 32'h0000_0400);
    checkOutput("post_rst_valid", {31'b0, valid_q}, 32'h1);

    // Register-file integration
    rf_mode = 1'b1;
    din = 8'd42;
    applyStimulus(1'b1, 5'd5);
    @(posedge clk); #1;
    en = 1'b0;
    checkOutput("rf_reg5", {24'b0, regs[5]}, 32'd42);
    checkOutput("rf_reg4", {24'b0, regs[4]}, 32'd0);
    checkOutput("rf_reg6", {24'b0, regs[6]}, 32'd0);
    din = 8'd7;
    applyStimulus(1'b1, 5'd0);
    @(posedge clk); #1;
    en = 1'b0;
    checkOutput("rf_reg0", {24'b0, regs[0]}, 32'd0);
    checkOutput("rf_reg5_kept", {24'b0, regs[5]}, 32'd42);
    rf_mode = 1'b0;

    // Random traffic with random reset pulses
    for (int n = 0; n < 1000; n++) begin
      r_en = 1'($urandom_range(0, 3) != 0);
      r_a  = 5'($urandom_range(0, 31));
      exp_f = r_en ? (32'h1 << r_a) : 32'h0;
      applyStimulus(r_en, r_a);
      checkOutput("rand_f", F, exp_f);
      if ($urandom_range(0, 9) == 0) begin
        #1 rst = 1'b1;
        #1;
        exp_q = 32'h0;
        exp_v = 1'b0;
        checkOutput("rand_rst_fq", F_q, exp_q);
        checkOutput("rand_rst_valid", {31'b0, valid_q}, {31'b0, exp_v});
        checkOutput("rand_rst_f", F, exp_f);
        rst = 1'b0;
      end
      @(posedge clk); #1;
      exp_q = exp_f;
      exp_v = r_en;
      checkOutput("rand_fq", F_q, exp_q);
      checkOutput("rand_valid", {31'b0, valid_q}, {31'b0, exp_v});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decoder_5to32.md
Name: decoder_5to32

Overview:
- Binary-to-one-hot decoder: a 5-bit address on A selects exactly one of 32 output lines on F.
- Used by the register file to turn the write address into per-register write-enable lines.
- The combinational output F has zero latency; this is the path the register file uses.
- A registered copy F_q (one cycle of latency, asynchronous reset) is provided for pipelined consumers.

Parameters:
- AW, 5: address width in bits.
- NOUT, 32: number of output lines. Must equal 2**AW; elaboration fails otherwise.

Ports:
- clk  input  1  clock; F_q and valid_q update on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears F_q and valid_q.
- en  input  1  decode enable; when 0, every output line is 0.
- A  input  AW (5)  binary select address.
- F  output  NOUT (32)  combinational one-hot decode of A.
- F_q  output  NOUT (32)  registered copy of F.
- valid_q  output  1  registered copy of en; indicates F_q holds a decode.

Behaviour:
- Combinational path:
  - F[i] = en & (A == i) for i = 0..31.
  - When en=1, exactly one bit of F is 1. When en=0, F = 32'h0000_0000.
  - Zero latency; no dependence on clk or rst. F is live even while rst=1.
- Bit ordering: F[0] corresponds to A=0, F[31] to A=31, so F = 1 << A.
- A=0 decodes normally to F[0]. Protecting register 0 is the register file's job, not this block's.
- Registered path:
  - On each rising clk edge with rst=0: F_q <= F and valid_q <= en.
  - Latency from A/en to F_q/valid_q is exactly one cycle.
- Reset:
  - When rst asserts, F_q = 0 and valid_q = 0 immediately, with no clock needed.
  - Both are held at 0 while rst=1.
  - On the first rising edge after rst deasserts, F_q and valid_q capture normally.
  - Reset asserted mid-stream discards the pending registered value.
- Invariant: popcount(F) <= 1 and popcount(F_q) <= 1 at all times.
- Unknown input: if A or en contains X/Z, F is don't-care in synthesis. Simulation models must drive F to all-X rather than a silently wrong one-hot value.
- The block has no internal state other than F_q and valid_q, and no handshake.

Test Plan:
- Exhaustive sweep: en=1, A=0..31 -> F == 32'h1 << A each step; popcount(F)==1; F_q equals the previous step's F one clock later.
- Boundaries: A=0 -> F=32'h0000_0001. A=31 -> F=32'h8000_0000. A=16 -> F=32'h0001_0000.
- Enable gating: en=0 while A sweeps 0..31 -> F=0 throughout. Next edge: F_q=0, valid_q=0.
- Asynchronous reset: with F_q=32'h0000_0400 (A=10 registered), pulse rst between clock edges -> F_q=0 and valid_q=0 immediately; F still 32'h0000_0400. After release, next edge -> F_q=32'h0000_0400, valid_q=1.
- Register-file integration: awr=5, we=1, din=42 -> only register 5 updates and reads back 42; awr=0 with din=7 -> register 0 still reads 0.
- Random: 1000 cycles of random A/en with random rst pulses -> F matches the reference model each cycle; F_q and valid_q match a one-cycle delayed model that is cleared asynchronously by rst.
